pipe_word_serializer: RTL and testbench

PIPE_WORD_SERIALIZER -- requirements
Module: pipe_word_serializer

---
 rtl/pipe_word_serializer_pkg.sv | 37 +++
 rtl/pipe_word_serializer_fifo.sv | 55 +++++
 rtl/pipe_word_serializer.sv | 128 ++++++++++++
 tb/tb_pipe_word_serializer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_word_serializer_pkg.sv
// Shared constants, state encoding and word-select helpers for pipe_word_serializer.
// Optional header words are enabled by defining SERIALIZER_HEADER_EN.
package pipe_word_serializer_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned MSG_W         = 96;
  localparam int unsigned WORDS_PER_MSG = 3;
  localparam logic [7:0]  HDR_LEN       = 8'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef SERIALIZER_HEADER_EN
    ST_HDR  = 2'd1,
`endif
    ST_DATA = 2'd2
  } state_t;

  // Select one 32-bit slice of a message, lowest slice first.
  function automatic logic [WORD_W-1:0] msg_word(input logic [MSG_W-1:0] msg,
                                                 input logic [1:0]       idx);
    logic [WORD_W-1:0] w;
    case (idx)
      2'd0:    w = msg[31:0];
      2'd1:    w = msg[63:32];
      default: w = msg[95:64];
    endcase
    return w;
  endfunction

`ifdef SERIALIZER_HEADER_EN
  // Header word: sequence number, reserved byte, payload length in words.
  function automatic logic [WORD_W-1:0] hdr_word(input logic [15:0] seq);
    return {seq, 8'h00, HDR_LEN};
  endfunction
`endif

endpackage

// File: rtl/pipe_word_serializer_fifo.sv
// Message FIFO for pipe_word_serializer: power-of-two depth, wrapping pointers.
// The head output looks one entry ahead while pop is asserted, so the
// consumer can load the next message's first word on the popping edge.
module msg_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Storage write; contents need no reset since count gates all reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Status flags and head view.
  always_comb begin
    full  = (count == CW'(DEPTH));
    empty = (count == '0);
    head  = pop ? mem[rd_ptr + AW'(1)] : mem[rd_ptr];
  end

endmodule

// File: rtl/pipe_word_serializer.sv
// Serializes 96-bit messages into three 32-bit words, lowest slice first.
// Define SERIALIZER_HEADER_EN to prefix each message with a sequence header word.
module pipe_word_serializer
  import pipe_word_serializer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   enq__ENA,
  input  logic [95:0]            enq_v,
  output logic                   enq__RDY,
  output logic                   word__ENA,
  output logic [31:0]            word_v,
  input  logic                   word__RDY,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam logic [1:0]  LAST_IDX = 2'(WORDS_PER_MSG - 1);

  state_t            state;
  logic [1:0]        idx;
  logic              rdy_en;
  logic              full;
  logic              empty;
  logic [MSG_W-1:0]  head;
  logic              push;
  logic              pop;
`ifdef SERIALIZER_HEADER_EN
  logic [15:0]       seq;
`endif

  // Accept and pop strobes.
  always_comb begin
    push     = enq__ENA && enq__RDY;
    pop      = word__ENA && word__RDY && (state == ST_DATA) && (idx == LAST_IDX);
    enq__RDY = rdy_en && !full;
  end

  msg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (MSG_W)
  ) u_fifo (
    .clk   (CLK),
    .rst   (nRST),
    .push  (push),
    .pop   (pop),
    .wdata (enq_v),
    .full  (full),
    .empty (empty),
    .count (level),
    .head  (head)
  );

  // Holds enq__RDY low during reset; it rises on the first edge after release.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) rdy_en <= 1'b0;
    else      rdy_en <= 1'b1;
  end

  // Serializer FSM with registered word outputs.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state     <= ST_IDLE;
      idx       <= '0;
      word__ENA <= 1'b0;
      word_v    <= '0;
`ifdef SERIALIZER_HEADER_EN
      seq       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            idx       <= '0;
            word__ENA <= 1'b1;
`ifdef SERIALIZER_HEADER_EN
            state     <= ST_HDR;
            word_v    <= hdr_word(seq);
`else
            state     <= ST_DATA;
            word_v    <= msg_word(head, 2'd0);
`endif
          end
        end
`ifdef SERIALIZER_HEADER_EN
        ST_HDR: begin
          if (word__RDY) begin
            seq    <= seq + 16'd1;
            state  <= ST_DATA;
            idx    <= '0;
            word_v <= msg_word(head, 2'd0);
          end
        end
`endif
        ST_DATA: begin
          if (word__RDY) begin
            if (idx == LAST_IDX) begin
              idx <= '0;
              // level still counts the popping entry, so >1 means another is queued.
              if (level > CW'(1)) begin
`ifdef SERIALIZER_HEADER_EN
                state  <= ST_HDR;
                word_v <= hdr_word(seq);
`else
                word_v <= msg_word(head, 2'd0);
`endif
              end else begin
                state     <= ST_IDLE;
                word__ENA <= 1'b0;
                word_v    <= '0;
              end
            end else begin
              idx    <= idx + 2'd1;
              word_v <= msg_word(head, idx + 2'd1);
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          word__ENA <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_word_serializer.sv
// Directed self-checking bench for pipe_word_serializer (DEPTH=2).
module tb_pipe_word_serializer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        enq__ENA;
  logic [95:0] enq_v;
  logic        enq__RDY;
  logic        word__ENA;
  logic [31:0] word_v;
  logic        word__RDY;
  logic [1:0]  level;

  int checks = 0;
  int errors = 0;

  localparam logic [95:0] MSG_A = 96'hCCCC_0003_BBBB_0002_AAAA_0001;
  localparam logic [95:0] MSG_B = 96'h3333_0006_2222_0005_1111_0004;
  localparam logic [95:0] MSG_C = 96'hDEAD_0009_BEEF_0008_F00D_0007;

  pipe_word_serializer #(.DEPTH(2)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .enq__ENA  (enq__ENA),
    .enq_v     (enq_v),
    .enq__RDY  (enq__RDY),
    .word__ENA (word__ENA),
    .word_v    (word_v),
    .word__RDY (word__RDY),
    .level     (level)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_w [8];

    nRST      = 1'b1;
    enq__ENA  = 1'b0;
    enq_v     = '0;
    word__RDY = 1'b1;
    tick();
    tick();
    chk("rst_word_ena", 32'(word__ENA), 32'd0);
    chk("rst_word_v",   word_v,         32'd0);
    chk("rst_enq_rdy",  32'(enq__RDY),  32'd0);
    chk("rst_level",    32'(level),     32'd0);
    nRST = 1'b0;
    tick();
    chk("post_rst_enq_rdy", 32'(enq__RDY), 32'd1);

`ifndef SERIALIZER_HEADER_EN
    // Single message, free-flowing output.
    enq_v = MSG_A; enq__ENA = 1'b1;
    tick();
    enq__ENA = 1'b0;
    chk("s1_lat_ena", 32'(word__ENA), 32'd0);
    chk("s1_level",   32'(level),     32'd1);
    tick();
    chk("s1_w0_ena", 32'(word__ENA), 32'd1);
    chk("s1_w0",     word_v, 32'hAAAA0001);
    tick();
    chk("s1_w1",     word_v, 32'hBBBB0002);
    tick();
    chk("s1_w2",     word_v, 32'hCCCC0003);
    chk("s1_w2_ena", 32'(word__ENA), 32'd1);
    tick();
    chk("s1_done_ena",   32'(word__ENA), 32'd0);
    chk("s1_done_level", 32'(level),     32'd0);

    // Back-pressure at idx1.
    enq_v = MSG_A; enq__ENA = 1'b1;
    tick();
    enq__ENA = 1'b0;
    tick();
    tick();
    chk("bp_w1", word_v, 32'hBBBB0002);
    word__RDY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_w",   word_v,         32'hBBBB0002);
      chk("bp_hold_ena", 32'(word__ENA), 32'd1);
      chk("bp_level",    32'(level),     32'd1);
    end
    word__RDY = 1'b1;
    tick();
    chk("bp_w2", word_v, 32'hCCCC0003);
    tick();
    chk("bp_done_ena", 32'(word__ENA), 32'd0);

    // Fill with output stalled; third enqueue is refused.
    word__RDY = 1'b0;
    enq_v = MSG_A; enq__ENA = 1'b1;
    tick();
    enq_v = MSG_B;
    chk("fill_rdy_1", 32'(enq__RDY), 32'd1);
    tick();
    chk("fill_level_2", 32'(level),    32'd2);
    chk("fill_rdy_0",   32'(enq__RDY), 32'd0);
    enq_v = MSG_C;
    tick();
    enq__ENA = 1'b0;
    chk("fill_ignored_level", 32'(level),    32'd2);
    chk("fill_still_full",    32'(enq__RDY), 32'd0);
    exp_w[0] = 32'hAAAA0001; exp_w[1] = 32'hBBBB0002; exp_w[2] = 32'hCCCC0003;
    exp_w[3] = 32'h11110004; exp_w[4] = 32'h22220005; exp_w[5] = 32'h33330006;
    word__RDY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("fill_word_ena", 32'(word__ENA), 32'd1);
      chk("fill_word",     word_v,         exp_w[i]);
      tick();
    end
    chk("fill_done_ena",   32'(word__ENA), 32'd0);
    chk("fill_done_level", 32'(level),     32'd0);
    tick();
    chk("fill_no_stale", 32'(word__ENA), 32'd0);

    // Reset mid-message discards everything.
    enq_v = MSG_A; enq__ENA = 1'b1;
    tick();
    enq_v = MSG_B;
    tick();
    enq__ENA = 1'b0;
    chk("rm_level_2", 32'(level), 32'd2);
    tick();
    chk("rm_w1", word_v, 32'hBBBB0002);
    #2;
    nRST = 1'b1;
    #1;
    chk("rm_async_ena",   32'(word__ENA), 32'd0);
    chk("rm_async_level", 32'(level),     32'd0);
    tick();
    nRST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rm_after_ena",   32'(word__ENA), 32'd0);
      chk("rm_after_level", 32'(level),     32'd0);
    end
    chk("rm_after_rdy", 32'(enq__RDY), 32'd1);
`else
    // Two back-to-back messages, each preceded by a header.
    enq_v = MSG_A; enq__ENA = 1'b1;
    tick();
    enq_v = MSG_B;
    tick();
    enq__ENA = 1'b0;
    exp_w[0] = 32'h00000003; exp_w[1] = 32'hAAAA0001; exp_w[2] = 32'hBBBB0002;
    exp_w[3] = 32'hCCCC0003; exp_w[4] = 32'h00010003; exp_w[5] = 32'h11110004;
    exp_w[6] = 32'h22220005; exp_w[7] = 32'h33330006;
    for (int i = 0; i < 8; i++) begin
      chk("hdr_word_ena", 32'(word__ENA), 32'd1);
      chk("hdr_word",     word_v,         exp_w[i]);
      tick();
    end
    chk("hdr_done_ena", 32'(word__ENA), 32'd0);

    // Sequence wrap from 16'hFFFF.
    force dut.seq = 16'hFFFF;
    tick();
    release dut.seq;
    enq_v = MSG_A; enq__ENA = 1'b1;
    tick();
    tick();
    enq__ENA = 1'b0;
    exp_w[0] = 32'hFFFF0003; exp_w[1] = 32'hAAAA0001; exp_w[2] = 32'hBBBB0002;
    exp_w[3] = 32'hCCCC0003; exp_w[4] = 32'h00000003; exp_w[5] = 32'hAAAA0001;
    exp_w[6] = 32'hBBBB0002; exp_w[7] = 32'hCCCC0003;
    for (int i = 0; i < 8; i++) begin
      chk("wrap_word_ena", 32'(word__ENA), 32'd1);
      chk("wrap_word",     word_v,         exp_w[i]);
      tick();
    end
    chk("wrap_done_ena", 32'(word__ENA), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
